// File: rtl/prog_loader_if.sv
// Host byte stream in, memory load port and CPU hold/status out, for prog_loader.
interface prog_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] entera;
  logic [7:0] enterd;
  logic       mem_we;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_err;

  modport master (
    output s_valid, s_data,
    input  s_ready, entera, enterd, mem_we, cpu_hold, busy, load_done, load_err
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, entera, enterd, mem_we, cpu_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: ADDR, LEN, LEN data bytes (+CSUM when LOADER_CHECKSUM_EN) written to memory load port.
// Latency: write strobe/addr/data one cycle after byte accept; load_done and cpu_hold fall registered at last-byte accept.
// Backpressure: none; s_ready is high every cycle out of reset and s_valid low simply stalls the current state.
module prog_loader #(
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
`else
    ST_DATA = 2'd2
`endif
  } state_t;

  state_t     state_q;
  logic       s_ready_q;
  logic [7:0] ptr_q;
  logic [8:0] cnt_q;
  logic [7:0] entera_q;
  logic [7:0] enterd_q;
  logic       mem_we_q;
  logic       cpu_hold_q;
  logic       load_done_q;
  logic       accept;
  logic [7:0] ptr_d;

  assign accept = bus.s_valid & s_ready_q;
  assign ptr_d  = ptr_q + 8'd1;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic       load_err_q;

  assign sum_d = sum_q + bus.s_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      ptr_q       <= 8'd0;
      cnt_q       <= 9'd0;
      entera_q    <= 8'd0;
      enterd_q    <= 8'd0;
      mem_we_q    <= 1'b0;
      cpu_hold_q  <= HOLD_AT_RESET;
      load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
      load_err_q  <= 1'b0;
`endif
    end else begin
      s_ready_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            ptr_q      <= bus.s_data;
            cpu_hold_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            load_err_q <= 1'b0;
`endif
            state_q    <= ST_LEN;
          end
          ST_LEN: begin
            // LEN of zero encodes a full 256-byte page
            cnt_q   <= (bus.s_data == 8'd0) ? 9'd256 : {1'b0, bus.s_data};
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
            state_q <= ST_DATA;
          end
          ST_DATA: begin
            entera_q <= ptr_q;
            enterd_q <= bus.s_data;
            mem_we_q <= 1'b1;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
            if (cnt_q == 9'd1) begin
              state_q <= ST_CSUM;
            end
`else
            if (cnt_q == 9'd1) begin
              state_q     <= ST_IDLE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          ST_CSUM: begin
            // A bad checksum leaves the CPU held so a corrupt image never runs
            if (bus.s_data == sum_q) begin
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              load_err_q  <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.entera    = entera_q;
  assign bus.enterd    = enterd_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.load_done = load_done_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.load_err  = load_err_q;
`else
  assign bus.load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: expected writes queued as data bytes are driven, popped on mem_we.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if bus();

  prog_loader #(.HOLD_AT_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk    = 0;
  int          n_err    = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic [7:0]  payload[256];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (bus.load_done === 1'b1) done_cnt++;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("we_without_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_w = exp_q.pop_front();
        chk("write_addr_data", {16'd0, bus.entera, bus.enterd}, {16'd0, exp_w});
      end
    end
  end

  task automatic put(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready",   32'(bus.s_ready),   32'd0);
    chk("rst_entera",    32'(bus.entera),    32'd0);
    chk("rst_enterd",    32'(bus.enterd),    32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_load_done", 32'(bus.load_done), 32'd0);
    chk("rst_load_err",  32'(bus.load_err),  32'd0);
    chk("rst_cpu_hold",  32'(bus.cpu_hold),  32'd1);
  endtask

  task automatic send_frame(input logic [7:0] addr, input int n, input bit stall, input bit bad_csum);
    int         d0 = done_cnt;
    logic [7:0] sum = 8'd0;
    logic [7:0] a = addr;
    logic [7:0] len_b;
    len_b = n[7:0];
    put(addr);
    chk("hold_after_addr", 32'(bus.cpu_hold), 32'd1);
    chk("busy_after_addr", 32'(bus.busy), 32'd1);
    if (stall) gap();
    put(len_b);
    if (stall) gap();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, payload[i]});
      a   = a + 8'd1;
      sum = sum + payload[i];
      put(payload[i]);
      if (stall && i != n - 1) gap();
    end
`ifdef LOADER_CHECKSUM_EN
    if (stall) gap();
    put(bad_csum ? sum + 8'd1 : sum);
`endif
    chk("done_pulse", 32'(bus.load_done), bad_csum ? 32'd0 : 32'd1);
    chk("hold_end",   32'(bus.cpu_hold),  bad_csum ? 32'd1 : 32'd0);
    chk("err_end",    32'(bus.load_err),  bad_csum ? 32'd1 : 32'd0);
    chk("busy_end",   32'(bus.busy),      32'd0);
    gap();
    chk("done_count", 32'(done_cnt - d0), bad_csum ? 32'd0 : 32'd1);
    chk("done_low",   32'(bus.load_done), 32'd0);
    chk("sb_empty",   32'(exp_q.size()),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b0;
    gap();
    chk("s_ready_up", 32'(bus.s_ready), 32'd1);

    // Basic back-to-back load
    payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
    send_frame(8'h10, 3, 1'b0, 1'b0);

    // Same frame with s_valid toggling every cycle
    send_frame(8'h10, 3, 1'b1, 1'b0);

    // LEN=0 means 256 bytes, address wraps through 0xFF
    for (int i = 0; i < 256; i++) payload[i] = 8'(i);
    send_frame(8'hFE, 256, 1'b0, 1'b0);

    // Reload after success re-asserts hold
    chk("hold_before_reload", 32'(bus.cpu_hold), 32'd0);
    payload[0] = 8'h5A;
    send_frame(8'h50, 1, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    payload[0] = 8'h01; payload[1] = 8'h02;
    send_frame(8'h20, 2, 1'b0, 1'b0);
    send_frame(8'h20, 2, 1'b0, 1'b1);
    repeat (3) gap();
    chk("err_sticky",  32'(bus.load_err), 32'd1);
    chk("hold_sticky", 32'(bus.cpu_hold), 32'd1);
    send_frame(8'h20, 2, 1'b0, 1'b0);
`endif

    // Reset after two data bytes of a five-byte frame
    put(8'h40);
    put(8'h05);
    exp_q.push_back({8'h40, 8'h11});
    put(8'h11);
    exp_q.push_back({8'h41, 8'h22});
    put(8'h22);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    chk("sb_empty_at_reset", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    gap();
    chk("s_ready_after_rst", 32'(bus.s_ready), 32'd1);
    payload[0] = 8'h31; payload[1] = 8'h32; payload[2] = 8'h33;
    payload[3] = 8'h34; payload[4] = 8'h35;
    send_frame(8'h60, 5, 1'b0, 1'b0);

    repeat (2) gap();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
